// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package disp_pkg;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex digit to active-high 7-segment pattern decoder.
module hex7seg_dec
    import disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed digit scanner: ON/BLANK slot per digit, frame-aligned shadow
// update through a load/load_ack handshake, registered pins with selectable polarity.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 1000,
    parameter int BLANK_TICKS = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic                    load_ack,
    input  logic                    disp_off,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start,
    output scan_state_e             dbg_state
);

    localparam int TW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] ON_LAST    = TW'(PRESCALE - BLANK_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || BLANK_TICKS < 1 || BLANK_TICKS >= PRESCALE) begin : g_param_check
        $fatal(1, "disp_scan_ctrl: illegal NUM_DIGITS/PRESCALE/BLANK_TICKS combination");
    end

    scan_state_e             state_q;
    logic [IW-1:0]           idx_q;
    logic [TW-1:0]           tick_q;
    logic                    first_q;
    logic [4*NUM_DIGITS-1:0] shadow_hex_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic                    pending_q;
    logic                    load_ack_q;
    logic                    frame_start_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;

    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [3:0]              cur_hex;
    logic [6:0]              cur_seg;
    logic                    blank_end;
    logic                    wrap;
    logic                    capture;

    hex7seg_dec u_dec (
        .hex_i (cur_hex),
        .seg_o (cur_seg)
    );

    always_comb begin
        cur_hex   = shadow_hex_q[4*idx_q +: 4];
        blank_end = ce && (state_q == ST_BLANK) && (tick_q == BLANK_LAST);
        // The reset-exit BLANK keeps idx at 0, so it can never look like a wrap.
        wrap      = blank_end && !first_q && (idx_q == IDX_LAST);
        // A load seen during the ack cycle belongs to the request just served.
        capture   = wrap && (pending_q || (load && !load_ack_q));
    end

    always_comb begin
        an_d  = '0;
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        if (state_q == ST_ON) begin
            seg_d = cur_seg;
            dp_d  = shadow_dp_q[idx_q];
            if (!disp_off) begin
                an_d[idx_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BLANK;
            idx_q         <= '0;
            tick_q        <= '0;
            first_q       <= 1'b1;
            shadow_hex_q  <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            an_q          <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q         <= SEG_OFF ^ {7{ACTIVE_LOW}};
            dp_q          <= ACTIVE_LOW;
        end else begin
            if (ce) begin
                if (state_q == ST_ON) begin
                    if (tick_q == ON_LAST) begin
                        tick_q  <= '0;
                        state_q <= ST_BLANK;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end else begin
                    if (tick_q == BLANK_LAST) begin
                        tick_q  <= '0;
                        state_q <= ST_ON;
                        first_q <= 1'b0;
                        if (!first_q) begin
                            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
            end

            if (capture) begin
                shadow_hex_q <= hex_in;
                shadow_dp_q  <= dp_in;
                pending_q    <= 1'b0;
            end else if (load && !load_ack_q) begin
                pending_q <= 1'b1;
            end

            load_ack_q    <= capture;
            frame_start_q <= wrap;
            an_q          <= an_d ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg_q         <= seg_d ^ {7{ACTIVE_LOW}};
            dp_q          <= dp_d ^ ACTIVE_LOW;
        end
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with 4 digits, 4-tick slots, 1 blank tick, active-low pins.
module tb_disp_scan_ctrl;
    import disp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        load_ack;
    logic        disp_off = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;
    scan_state_e dbg_state;

    int n_total = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    // Independent copy of the active-high segment patterns.
    logic [6:0] seg_tbl [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    disp_scan_ctrl #(
        .NUM_DIGITS  (4),
        .PRESCALE    (4),
        .BLANK_TICKS (1),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .hex_in      (hex_in),
        .dp_in       (dp_in),
        .load        (load),
        .load_ack    (load_ack),
        .disp_off    (disp_off),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Walks one full frame starting right after a frame_start/ack sample.
    task automatic check_frame(input logic [15:0] hex, input logic [3:0] dps);
        logic [7:0] exp_v;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [3:0] exp_an;
        int d;
        int ph;
        exp_v = '0;
        for (int i = 0; i < 4; i++) exp_q.push_back({dps[i], seg_tbl[hex[4*i +: 4]]});
        for (int s = 1; s <= 16; s++) begin
            tick();
            d  = (s - 1) / 4;
            ph = (s - 1) % 4;
            if (ph == 0) exp_v = exp_q.pop_front();
            if (ph < 3) begin
                exp_an  = ~(4'b0001 << d);
                exp_seg = ~exp_v[6:0];
                exp_dp  = ~exp_v[7];
                chk("frame_an", an, exp_an);
                chk("frame_seg", seg, exp_seg);
                chk("frame_dp", dp, exp_dp);
            end else begin
                chk("blank_an", an, 4'hF);
                chk("blank_seg", seg, 7'h7F);
            end
            chk("frame_start", frame_start, (s == 16));
            chk("frame_ack_idle", load_ack, 1'b0);
        end
    endtask

    initial begin
        int  cnt;
        bit  seen;
        bit  off_ok;

        // Reset state
        tick();
        tick();
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_ack", load_ack, 1'b0);
        chk("rst_fs", frame_start, 1'b0);

        rst = 1'b1;
        tick();
        chk("exit_blank_an", an, 4'hF);
        chk("exit_fs", frame_start, 1'b0);
        tick();
        chk("exit_first_an", an, 4'b1110);
        chk("exit_first_seg", seg, 7'h40);

        // Load request acked at the frame wrap
        hex_in = 16'h1F80;
        dp_in  = 4'b0010;
        load   = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 20) begin
            tick();
            cnt++;
            seen = load_ack;
        end
        chk("ack_seen", seen, 1'b1);
        chk("ack_latency", (cnt <= 16), 1'b1);
        chk("ack_with_fs", frame_start, 1'b1);
        load = 1'b0;
        check_frame(16'h1F80, 4'b0010);

        // ce freeze mid-ON on digit 0
        tick();
        chk("pre_freeze_an", an, 4'b1110);
        ce = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("freeze_an", an, 4'b1110);
            chk("freeze_seg", seg, 7'h40);
            chk("freeze_fs", frame_start, 1'b0);
        end
        ce = 1'b1;
        tick();
        chk("resume_an0", an, 4'b1110);
        tick();
        chk("resume_an1", an, 4'b1110);
        tick();
        chk("resume_blank", an, 4'hF);
        tick();
        chk("resume_next", an, 4'b1101);
        chk("resume_next_seg", seg, 7'h00);
        chk("resume_next_dp", dp, 1'b0);

        // disp_off blanks anodes while scanning and handshake continue
        disp_off = 1'b1;
        tick();
        chk("off_an", an, 4'hF);
        hex_in = 16'hA5C3;
        dp_in  = 4'b1001;
        load   = 1'b1;
        cnt    = 0;
        seen   = 1'b0;
        off_ok = 1'b1;
        while (!seen && cnt < 40) begin
            tick();
            cnt++;
            if (an !== 4'hF) off_ok = 1'b0;
            seen = load_ack;
        end
        chk("off_an_held", off_ok, 1'b1);
        chk("off_ack_seen", seen, 1'b1);
        chk("off_ack_fs", frame_start, 1'b1);
        load     = 1'b0;
        disp_off = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            tick();
            cnt++;
            if (cnt == 1) begin
                chk("new_an", an, 4'b1110);
                chk("new_seg", seg, 7'h30);
                chk("new_dp", dp, 1'b0);
            end
            seen = frame_start;
        end
        chk("fs_period", cnt, 16);

        // Asynchronous reset mid-ON
        tick();
        chk("pre_arst_an", an, 4'b1110);
        rst = 1'b0;
        #2;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_dp", dp, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("arst_exit_an", an, 4'hF);
        chk("arst_exit_fs", frame_start, 1'b0);
        check_frame(16'h0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
